// File: rtl/bcd_stream_ctrl.sv
// bcd_stream_ctrl: prescaled cascade of ASCII decimal digit counters.
// Every increment snapshots the digit string and streams it MSB-first,
// followed by a terminator byte, over a valid/ready byte interface.
//
// Handshake: a byte transfers on a rising edge where tx_valid && tx_ready.
// Once tx_valid is raised, tx_data and tx_valid stay unchanged until that
// transfer happens; tx_valid never depends combinationally on tx_ready.
module bcd_stream_ctrl #(
  parameter int         DIGITS   = 4,
  parameter int         PRESCALE = 16,
  parameter logic [7:0] START    = 8'h30,
  parameter logic [7:0] STOP     = 8'h39,
  parameter logic [7:0] TERM     = 8'h0D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clear,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow,
  output logic       missed
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_TERM = 2'd2
  } state_t;

  logic [PW-1:0]            presc_q;
  logic                     presc_wrap;
  logic                     inc;
  logic [DIGITS-1:0][7:0]   digit_q;
  logic [DIGITS-1:0][7:0]   digit_nx;
  logic                     all_stop;
  logic [DIGITS-1:0][7:0]   shadow_q;
  logic [DIGITS-1:0][7:0]   shadow_d;
  logic [IW-1:0]            idx_q;
  logic [IW-1:0]            idx_d;
  state_t                   state_q;
  state_t                   state_d;
  logic [7:0]               tx_data_q;
  logic [7:0]               tx_data_d;
  logic                     tx_valid_q;
  logic                     tx_valid_d;
  logic                     overflow_q;
  logic                     missed_q;

  // Prescaler terminal count; clear wins over a coincident increment.
  assign presc_wrap = en && (presc_q == PW'(PRESCALE - 1));
  assign inc        = presc_wrap && !clear;

  // Prescaler: counts 0..PRESCALE-1 while enabled, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (clear) begin
      presc_q <= '0;
    end else if (en) begin
      if (presc_wrap) presc_q <= '0;
      else            presc_q <= presc_q + PW'(1);
    end
  end

  // Single-cycle ripple: digit i steps only when all lower digits sit at STOP.
  always_comb begin
    logic carry;
    carry    = 1'b1;
    digit_nx = digit_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        digit_nx[i] = (digit_q[i] == STOP) ? START : digit_q[i] + 8'd1;
      end
      carry = carry && (digit_q[i] == STOP);
    end
    all_stop = carry;
  end

  // Digit registers, overflow pulse and sticky missed-snapshot flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q    <= {DIGITS{START}};
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
    end else if (clear) begin
      digit_q    <= {DIGITS{START}};
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      if (inc) digit_q <= digit_nx;
      overflow_q <= inc && all_stop;
      if (inc && (state_q != ST_IDLE)) missed_q <= 1'b1;
    end
  end

  // Stream FSM state and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      shadow_q   <= {DIGITS{START}};
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Next-state: snapshot on inc in IDLE, walk digits MSB-first, then TERM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (inc) begin
          state_d    = ST_SEND;
          idx_d      = IW'(DIGITS - 1);
          shadow_d   = digit_nx;
          tx_data_d  = digit_nx[DIGITS-1];
          tx_valid_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx_q != '0) begin
            idx_d     = idx_q - IW'(1);
            tx_data_d = shadow_q[idx_q - IW'(1)];
          end else begin
            state_d   = ST_TERM;
            tx_data_d = TERM;
          end
        end
      end
      ST_TERM: begin
        if (tx_ready) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign overflow = overflow_q;
  assign missed   = missed_q;

endmodule

// File: tb/tb_bcd_stream_ctrl.sv
// Directed bench for bcd_stream_ctrl (DIGITS=2, PRESCALE=4).
// Expected bytes are queued when a stream is anticipated and popped on
// every accepted beat; cycle-level checks cover timing and flags.
module tb_bcd_stream_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overflow;
  logic       missed;

  logic [7:0] exp_q[$];
  int         errors;
  int         checks;

  bcd_stream_ctrl #(
    .DIGITS  (2),
    .PRESCALE(4),
    .START   (8'h30),
    .STOP    (8'h39),
    .TERM    (8'h0D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clear   (clear),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .overflow(overflow),
    .missed  (missed)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Queue the three bytes of a two-digit stream for value v.
  task automatic push_stream(input int v);
    exp_q.push_back(8'(8'h30 + (v / 10) % 10));
    exp_q.push_back(8'(8'h30 + v % 10));
    exp_q.push_back(8'h0D);
  endtask

  // Scoreboard sample at the falling edge, then advance to just past the next rising edge.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    if (rst_n && tx_valid && tx_ready) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(tx_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    clear    = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_missed", 32'(missed), 32'd0);
    rst_n = 1'b1;
    step();
    en = 1'b1;

    // Free-running count 01..99 then wrap to 00: one stream every 4 cycles.
    for (int v = 1; v <= 100; v++) push_stream(v);
    for (int c = 1; c <= 400; c++) begin
      step();
      chk("ovf_pulse", 32'(overflow), 32'(c == 400));
      if (c % 4 == 0) begin
        chk("stream_start_valid", 32'(tx_valid), 32'd1);
        chk("stream_start_busy", 32'(busy), 32'd1);
        chk("stream_start_msd", 32'(tx_data), 32'(8'h30 + ((c / 4) % 100) / 10));
      end else if (c % 4 == 3) begin
        chk("idle_valid", 32'(tx_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
      end
    end
    chk("no_missed_free_run", 32'(missed), 32'd0);

    // Backpressure: "00" stream stalls on its first byte while digits advance to 05.
    tx_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'h30);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    chk("stall_missed", 32'(missed), 32'd1);
    push_stream(6);
    tx_ready = 1'b1;
    repeat (3) step();
    chk("stall_done_busy", 32'(busy), 32'd0);
    chk("missed_sticky", 32'(missed), 32'd1);
    step();
    chk("after_stall_valid", 32'(tx_valid), 32'd1);
    chk("after_stall_msd", 32'(tx_data), 32'h30);
    repeat (3) step();
    chk("pre_clear_busy", 32'(busy), 32'd0);

    // Clear coincident with an increment: no stream, flags cleared.
    clear = 1'b1;
    step();
    chk("clear_valid", 32'(tx_valid), 32'd0);
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_missed", 32'(missed), 32'd0);
    chk("clear_ovf", 32'(overflow), 32'd0);
    clear = 1'b0;
    repeat (2) step();

    // Enable low for 10 cycles with prescaler at 2: it must resume from there.
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("en_low_valid", 32'(tx_valid), 32'd0);
    end
    en = 1'b1;
    push_stream(1);
    step();
    chk("hold_not_yet", 32'(tx_valid), 32'd0);
    step();
    chk("hold_resume_valid", 32'(tx_valid), 32'd1);
    chk("hold_resume_msd", 32'(tx_data), 32'h30);

    // Asynchronous reset in the middle of a stream.
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(tx_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ovf", 32'(overflow), 32'd0);
    chk("async_data", 32'(tx_data), 32'h00);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    push_stream(1);
    repeat (3) step();
    chk("post_rst_not_yet", 32'(tx_valid), 32'd0);
    step();
    chk("post_rst_valid", 32'(tx_valid), 32'd1);
    chk("post_rst_msd", 32'(tx_data), 32'h30);
    repeat (3) step();
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
